ltc2333_sequencer: RTL and testbench

Parametrised successor to the LTC2333 write-only controller, driving CNV/SCKI/SDI to the LTC2333 ADC. All settings are run-time ports latched at start: channel mask, per-channel SoftSpan, sample period, read count and mode. It also captures SDO into 24-bit result words on a ready/valid stream. It sits between the ADC pins and the DAQ/AXI-stream packetiser.

---
 rtl/ltc2333_pkg.sv | 37 +++
 rtl/ltc2333_frame_capture.sv | 56 +++++
 rtl/ltc2333_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_ltc2333_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ltc2333_pkg.sv
// Shared types, constants and helpers for the LTC2333 sequencer.
package ltc2333_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_XFER,
    S_WAIT
  } state_t;

  localparam int         FRAME_BITS  = 24;
  localparam int         CTRL_BITS   = 8;
  localparam logic [1:0] CTRL_PREFIX = 2'b10;

  function automatic logic [CTRL_BITS-1:0] ctrl_byte(input logic [2:0] ch,
                                                     input logic [2:0] span);
    return {CTRL_PREFIX, ch, span};
  endfunction

  // Lowest active channel above ch, wrapping; returns ch itself if it is the only one.
  function automatic logic [2:0] next_active(input logic [7:0] mask, input logic [2:0] ch);
    logic [2:0] idx;
    logic [2:0] res;
    logic       found;
    res   = ch;
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      idx = ch + 3'(i);
      if (!found && mask[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ltc2333_frame_capture.sv
// SDO deserialiser with a one-entry ready/valid holding register and overrun flag.
module ltc2333_frame_capture
  import ltc2333_pkg::*;
(
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  clear,
  input  logic                  sample,
  input  logic                  discard,
  input  logic                  sdo,
  input  logic                  out_ready,
  output logic [FRAME_BITS-1:0] out_data,
  output logic                  out_valid,
  output logic                  overrun
);

  logic [FRAME_BITS-1:0] shift;
  logic [4:0]            bit_cnt;
  logic                  done;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      shift     <= '0;
      bit_cnt   <= '0;
      done      <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (sample) begin
        shift <= {shift[FRAME_BITS-2:0], sdo};
        if (bit_cnt == 5'(FRAME_BITS - 1)) begin
          bit_cnt <= '0;
          done    <= !discard;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
      if (clear) bit_cnt <= '0;

      if (out_valid && out_ready) out_valid <= 1'b0;
      // A completed frame is presented the cycle after its last bit lands in shift.
      if (done) begin
        if (!out_valid || out_ready) begin
          out_data  <= shift;
          out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
      if (clear) overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/ltc2333_sequencer.sv
// LTC2333 CNV/SCKI/SDI sequencer; define LTC2333_SDO_CAPTURE_EN to add SDO frame capture.
module ltc2333_sequencer
  import ltc2333_pkg::*;
#(
  parameter int NCHAN           = 8,
  parameter int CLOCK_PERIOD_NS = 20,
  parameter int BUSY_TIME_NS    = 550,
  parameter int BUSY_SIGNAL     = 0,
  parameter int PERIOD_W        = 32
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic [NCHAN-1:0]      cfg_chan_mask,
  input  logic [3*NCHAN-1:0]    cfg_range,
  input  logic [PERIOD_W-1:0]   cfg_period,
  input  logic [15:0]           cfg_n_reads,
  input  logic                  cfg_continuous,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  busy,
  input  logic                  sdo,
  output logic                  cnv,
  output logic                  scki,
  output logic                  sdi,
  output logic [FRAME_BITS-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  active,
  output logic                  timing_err,
  output logic                  overrun,
  output logic                  cfg_err
);

  localparam int CONV_CYC = BUSY_TIME_NS / CLOCK_PERIOD_NS + 2;
  localparam int BIT_W    = $clog2(FRAME_BITS * NCHAN + 1);
  localparam int K_W      = $clog2(NCHAN + 1);

  state_t                    state;
  logic [NCHAN-1:0]          mask_l;
  logic [NCHAN-1:0][2:0]     range_l;
  logic [PERIOD_W-1:0]       period_l;
  logic                      cont_l;
  logic [K_W-1:0]            k_l;
  logic [BIT_W-1:0]          bit_last;
  logic [BIT_W-1:0]          bit_cnt;
  logic [2:0]                cur_ch;
  logic [CTRL_BITS-2:0]      sdi_sr;
  logic [16:0]               remaining;
  logic                      prime;
  logic                      stop_pend;
  logic [PERIOD_W-1:0]       cnt;
  logic [1:0]                busy_ff;
  logic                      clk_en;

  logic [K_W-1:0]            k_in;
  logic                      start_ok;
  logic [PERIOD_W:0]         cnt_p1;
  logic                      wait_done;
  logic                      late;
  logic                      conv_done;
  logic [PERIOD_W-1:0]       cnt_inc;
  logic [BIT_W-1:0]          bit_nxt;
  logic                      reload;
  logic [2:0]                first_ch;
  logic [2:0]                nxt_ch;
  logic [2:0]                sel_ch;
  logic [CTRL_BITS-1:0]      ld_byte;

  assign k_in      = K_W'($countones(cfg_chan_mask));
  assign start_ok  = (state == S_IDLE) && start && (k_in != '0) &&
                     (cfg_continuous || (cfg_n_reads != '0));
  assign cnt_p1    = {1'b0, cnt} + 1'b1;
  assign wait_done = cnt_p1 >= {1'b0, period_l};
  assign late      = cnt_p1 > {1'b0, period_l};
  assign conv_done = (BUSY_SIGNAL != 0) ? (!busy_ff[1] && (cnt >= PERIOD_W'(2)))
                                        : (cnt == PERIOD_W'(CONV_CYC - 1));
  assign cnt_inc   = (&cnt) ? cnt : cnt + 1'b1;
  assign bit_nxt   = bit_cnt + 1'b1;
  assign reload    = (bit_nxt[2:0] == 3'd0) && (bit_nxt[BIT_W-1:3] < (BIT_W-3)'(k_l));
  assign first_ch  = next_active(8'(mask_l), 3'(NCHAN - 1));
  assign nxt_ch    = next_active(8'(mask_l), cur_ch);
  assign sel_ch    = (state == S_CONV) ? first_ch : nxt_ch;
  assign ld_byte   = ctrl_byte(sel_ch, range_l[sel_ch]);
  assign scki      = clk_en & ~clk;

  // NOTE: every register here uses <= so all branches see the pre-edge state.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= S_IDLE;
      active     <= 1'b0;
      cnv        <= 1'b0;
      clk_en     <= 1'b0;
      sdi        <= 1'b0;
      sdi_sr     <= '0;
      timing_err <= 1'b0;
      cfg_err    <= 1'b0;
      mask_l     <= '0;
      range_l    <= '0;
      period_l   <= '0;
      cont_l     <= 1'b0;
      k_l        <= '0;
      bit_last   <= '0;
      bit_cnt    <= '0;
      cur_ch     <= '0;
      remaining  <= '0;
      prime      <= 1'b0;
      stop_pend  <= 1'b0;
      cnt        <= '0;
      busy_ff    <= '0;
    end else begin
      cfg_err <= 1'b0;
      busy_ff <= {busy_ff[0], busy};
      cnt     <= cnt_inc;
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            mask_l     <= cfg_chan_mask;
            range_l    <= cfg_range;
            period_l   <= cfg_period;
            cont_l     <= cfg_continuous;
            k_l        <= k_in;
            bit_last   <= BIT_W'(FRAME_BITS * k_in - 1);
            timing_err <= 1'b0;
            // n_reads+1 conversions, one of which is consumed by this CONV entry.
            remaining  <= {1'b0, cfg_n_reads};
            prime      <= 1'b1;
            stop_pend  <= 1'b0;
            cnt        <= '0;
            cnv        <= 1'b1;
            active     <= 1'b1;
            state      <= S_CONV;
          end else if (start) begin
            cfg_err <= 1'b1;
          end
        end
        S_CONV: begin
          if (stop) stop_pend <= 1'b1;
          if (conv_done) begin
            cnv            <= 1'b0;
            clk_en         <= 1'b1;
            bit_cnt        <= '0;
            cur_ch         <= first_ch;
            {sdi, sdi_sr}  <= ld_byte;
            state          <= S_XFER;
          end
        end
        S_XFER: begin
          if (stop) stop_pend <= 1'b1;
          bit_cnt <= bit_nxt;
          if (bit_cnt == bit_last) begin
            clk_en <= 1'b0;
            sdi    <= 1'b0;
            prime  <= 1'b0;
            state  <= S_WAIT;
          end else if (reload) begin
            cur_ch        <= nxt_ch;
            {sdi, sdi_sr} <= ld_byte;
          end else begin
            {sdi, sdi_sr} <= {sdi_sr, 1'b0};
          end
        end
        S_WAIT: begin
          if (stop) begin
            active <= 1'b0;
            state  <= S_IDLE;
          end else if (wait_done) begin
            if (late) timing_err <= 1'b1;
            if (stop_pend || (!cont_l && remaining == '0)) begin
              active <= 1'b0;
              state  <= S_IDLE;
            end else begin
              cnv   <= 1'b1;
              cnt   <= '0;
              state <= S_CONV;
              if (remaining != '0) remaining <= remaining - 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef LTC2333_SDO_CAPTURE_EN
  ltc2333_frame_capture u_capture (
    .clk       (clk),
    .aresetn   (aresetn),
    .clear     (start_ok),
    .sample    (state == S_XFER),
    .discard   (prime),
    .sdo       (sdo),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .overrun   (overrun)
  );
`else
  logic unused_capture;
  assign unused_capture = sdo ^ out_ready ^ prime;
  assign out_data  = '0;
  assign out_valid = 1'b0;
  assign overrun   = 1'b0;
`endif

endmodule

// File: tb/tb_ltc2333_sequencer.sv
// Scoreboard bench: an SDO model pushes expected frames, a monitor pops them on acceptance.
module tb_ltc2333_sequencer;

`ifdef LTC2333_SDO_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic [7:0]  cfg_chan_mask = '0;
  logic [23:0] cfg_range = '0;
  logic [31:0] cfg_period = '0;
  logic [15:0] cfg_n_reads = '0;
  logic        cfg_continuous = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        busy = 1'b0;
  logic        sdo = 1'b0;
  logic        cnv, scki, sdi, out_valid, active, timing_err, overrun, cfg_err;
  logic        out_ready = 1'b1;
  logic [23:0] out_data;

  ltc2333_sequencer dut (
    .clk(clk), .aresetn(aresetn), .cfg_chan_mask(cfg_chan_mask), .cfg_range(cfg_range),
    .cfg_period(cfg_period), .cfg_n_reads(cfg_n_reads), .cfg_continuous(cfg_continuous),
    .start(start), .stop(stop), .busy(busy), .sdo(sdo), .cnv(cnv), .scki(scki), .sdi(sdi),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .active(active),
    .timing_err(timing_err), .overrun(overrun), .cfg_err(cfg_err)
  );

  always #10 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          n_words = 0;
  int          conv_idx = 0;
  int          pulse_idx = 0;
  int          scki_cnt = 0;
  int          bitpos = 0;
  int          cnv_t[$];
  logic [23:0] exp_q[$];
  logic [7:0]  sdi_bytes[$];
  logic [7:0]  tb_mask = '0;
  logic [23:0] tb_range = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] nth_chan(input logic [7:0] m, input int j);
    int         seen = 0;
    logic [2:0] r = '0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        if (seen == j) r = 3'(i);
        seen++;
      end
    end
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge cnv);
    cnv_t.push_back(cyc);
    conv_idx++;
    pulse_idx = 0;
  end

  // ADC model: records SDI on scki rise and drives one SDO bit per pulse.
  initial begin : adc_model
    logic [7:0]  sdi_acc;
    logic [23:0] frame;
    logic [2:0]  ch;
    sdi_acc = '0;
    frame   = '0;
    forever begin
      @(posedge scki);
      sdi_acc = {sdi_acc[6:0], sdi};
      bitpos++;
      if (bitpos % 8 == 0) sdi_bytes.push_back(sdi_acc);
      scki_cnt++;
      if (pulse_idx % 24 == 0) begin
        ch    = nth_chan(tb_mask, pulse_idx / 24);
        frame = {18'($urandom), ch, tb_range[3*ch +: 3]};
        if (CAP && conv_idx > 1) exp_q.push_back(frame);
      end
      sdo = frame[23 - (pulse_idx % 24)];
      pulse_idx++;
    end
  end

  initial forever begin
    @(negedge clk);
    if (aresetn && out_valid && out_ready) begin
      n_words++;
      check("sb_nonempty", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("word", out_data, exp_q.pop_front());
    end
  end

  task automatic start_run(input logic [7:0] m, input logic [23:0] r, input logic [31:0] p,
                           input logic [15:0] n, input logic c);
    @(negedge clk);
    cfg_chan_mask  = m;
    cfg_range      = r;
    cfg_period     = p;
    cfg_n_reads    = n;
    cfg_continuous = c;
    tb_mask        = m;
    tb_range       = r;
    conv_idx       = 0;
    bitpos         = 0;
    scki_cnt       = 0;
    cnv_t.delete();
    sdi_bytes.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && active; i++) @(negedge clk);
    check("idle_reached", active, 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          w0;
    logic [23:0] r;
    logic [23:0] held_exp;

    // Reset values
    #25;
    check("rst_cnv", cnv, 0);
    check("rst_scki", scki, 0);
    check("rst_sdi", sdi, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_active", active, 0);
    check("rst_timing_err", timing_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_cfg_err", cfg_err, 0);
    @(negedge clk);
    aresetn = 1'b1;
    repeat (2) @(negedge clk);

    // Single-channel one-shot
    w0 = n_words;
    start_run(8'h10, 24'(3'b111) << 12, 500, 2, 1'b0);
    check("t1_cnv_latency", cnv, 1);
    check("t1_cfg_err", cfg_err, 0);
    wait_idle(4000);
    repeat (4) @(negedge clk);
    check("t1_cnv_count", cnv_t.size(), 3);
    for (int i = 1; i < cnv_t.size(); i++) check("t1_spacing", cnv_t[i] - cnv_t[i-1], 500);
    check("t1_scki", scki_cnt, 72);
    check("t1_sdi_byte0", sdi_bytes.size() > 0 ? sdi_bytes[0] : 8'hxx, 8'hA7);
    check("t1_sdi_byte1", sdi_bytes.size() > 1 ? sdi_bytes[1] : 8'hxx, 8'h00);
    check("t1_words", n_words - w0, CAP ? 2 : 0);
    check("t1_timing_err", timing_err, 0);
    check("t1_sb_empty", exp_q.size(), 0);

    // Multi-channel continuous with stop during a transfer
    w0 = n_words;
    start_run(8'h81, 24'h0, 300, 0, 1'b1);
    for (int i = 0; i < 5000 && cnv_t.size() < 4; i++) @(negedge clk);
    check("t2_reached_4", 32'(cnv_t.size() >= 4), 1);
    repeat (40) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_idle(1000);
    repeat (4) @(negedge clk);
    check("t2_cnv_count", cnv_t.size(), 4);
    check("t2_scki", scki_cnt, 4 * 48);
    check("t2_sdi_byte0", sdi_bytes.size() > 0 ? sdi_bytes[0] : 8'hxx, 8'h80);
    check("t2_sdi_byte1", sdi_bytes.size() > 1 ? sdi_bytes[1] : 8'hxx, 8'hB8);
    check("t2_sdi_byte2", sdi_bytes.size() > 2 ? sdi_bytes[2] : 8'hxx, 8'h00);
    check("t2_words", n_words - w0, CAP ? 6 : 0);
    check("t2_sb_empty", exp_q.size(), 0);

    // Rejected starts
    start_run(8'h00, 24'h0, 300, 5, 1'b0);
    check("t3a_cfg_err", cfg_err, 1);
    @(negedge clk);
    check("t3a_cfg_err_pulse", cfg_err, 0);
    start_run(8'h01, 24'h0, 300, 0, 1'b0);
    check("t3b_cfg_err", cfg_err, 1);
    repeat (50) @(negedge clk);
    check("t3_cnv_never", cnv_t.size(), 0);
    check("t3_active", active, 0);

    // Period too short, all channels
    w0 = n_words;
    r  = 24'($urandom);
    start_run(8'hFF, r, 100, 2, 1'b0);
    wait_idle(2000);
    repeat (4) @(negedge clk);
    check("t4_timing_err", timing_err, 1);
    check("t4_cnv_count", cnv_t.size(), 3);
    for (int i = 1; i < cnv_t.size(); i++) check("t4_spacing", cnv_t[i] - cnv_t[i-1], 29 + 192 + 1);
    check("t4_sdi_bytes_n", 32'(sdi_bytes.size() >= 8), 1);
    for (int i = 0; i < 8 && i < sdi_bytes.size(); i++)
      check("t4_sdi_byte", sdi_bytes[i], {2'b10, 3'(i), r[3*i +: 3]});
    check("t4_words", n_words - w0, CAP ? 16 : 0);

    // Backpressure: hold one frame, drop the next
    out_ready = 1'b0;
    start_run(8'h01, 24'h5, 100, 2, 1'b0);
    wait_idle(2000);
    check("t5_timing_err_clr", timing_err, 0);
    held_exp = exp_q.size() > 0 ? exp_q[0] : 24'h0;
    check("t5_sb_depth", exp_q.size(), CAP ? 2 : 0);
    check("t5_held_valid", out_valid, CAP);
    check("t5_held_data", out_data, held_exp);
    check("t5_overrun", overrun, CAP);
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    w0 = n_words;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_drained", out_valid, 0);
    start_run(8'h01, 24'h5, 100, 1, 1'b0);
    check("t5_overrun_cleared", overrun, 0);
    wait_idle(2000);
    repeat (4) @(negedge clk);
    check("t5_words", n_words - w0, CAP ? 2 : 0);
    check("t5_sb_empty", exp_q.size(), 0);

    // Reset during the priming transfer
    w0 = n_words;
    start_run(8'h01, 24'h3, 500, 2, 1'b0);
    for (int i = 0; i < 200 && scki_cnt < 9; i++) @(posedge clk);
    check("t6_reached_pulse9", scki_cnt, 9);
    @(negedge clk);
    #2;
    aresetn = 1'b0;
    #1;
    check("t6_cnv", cnv, 0);
    check("t6_scki", scki, 0);
    check("t6_sdi", sdi, 0);
    check("t6_active", active, 0);
    check("t6_out_valid", out_valid, 0);
    check("t6_out_data", out_data, 0);
    check("t6_timing_err", timing_err, 0);
    check("t6_overrun", overrun, 0);
    @(negedge clk);
    aresetn = 1'b1;
    repeat (300) @(negedge clk);
    check("t6_no_words", n_words - w0, 0);
    check("t6_cnv_count", cnv_t.size(), 1);
    check("t6_idle", active, 0);
    check("t6_sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
